// File: rtl/traffic_light_monitor_pkg.sv
// Shared types for the traffic light monitor.
// Holds the FSM states, fault codes and the lamp decoder.
package traffic_pkg;

  typedef enum logic [2:0] {
    SYNC,
    ALL_RED,
    NS_GO,
    EW_GO,
    FAULT
  } state_e;

  typedef enum logic [1:0] {
    L_STOP,
    L_GO,
    L_BAD
  } lamp_e;

  localparam logic [2:0] FC_NONE     = 3'd0;
  localparam logic [2:0] FC_CONFLICT = 3'd1;
  localparam logic [2:0] FC_ENCODING = 3'd2;
  localparam logic [2:0] FC_NO_CLEAR = 3'd3;
  localparam logic [2:0] FC_SHORT    = 3'd4;
  localparam logic [2:0] FC_LONG     = 3'd5;

  function automatic lamp_e lamp_decode(
    input logic g,
    input logic r
  );
    lamp_e l;
    case ({g, r})
      2'b10:   l = L_GO;
      2'b01:   l = L_STOP;
      default: l = L_BAD;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_light_monitor_sat_counter.sv
// Saturating up-counter with synchronous load-to-one.
// Measures how long the monitor has stayed in one state.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_d, q_q;

  // next value: load wins, otherwise count up and stick at all-ones
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = W'(1);
    end else if (inc && (q_q != '1)) begin
      q_d = q_q + 1'b1;
    end
  end

  // counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker on the four lamp outputs of the traffic controller.
// Tracks phases, times dwells and latches the first safety violation.
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN  = 4,
  parameter int MAX_GREEN  = 32,
  parameter int MIN_ALLRED = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             NS_green,
  input  logic             NS_red,
  input  logic             EW_green,
  input  logic             EW_red,
  input  logic             clr_fault,
  output logic             fault,
  output logic [2:0]       fault_code,
  output logic             phase_done,
  output logic             phase_dir,
  output logic [CNT_W-1:0] dwell,
  output logic [CNT_W-1:0] cycle_count
);

  state_e state_q, state_d;
  lamp_e  ns_l, ew_l, own_l, oth_l;
  logic   conflict, bad, done;
  logic [2:0] viol;

  logic             fault_q, fault_d;
  logic [2:0]       code_q, code_d;
  logic             done_q, done_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] dwell_q;

  assign ns_l     = lamp_decode(NS_green, NS_red);
  assign ew_l     = lamp_decode(EW_green, EW_red);
  assign own_l    = (state_q == EW_GO) ? ew_l : ns_l;
  assign oth_l    = (state_q == EW_GO) ? ns_l : ew_l;
  assign conflict = NS_green & EW_green;
  assign bad      = (ns_l == L_BAD) || (ew_l == L_BAD);

  // dwell restarts at one whenever the state changes
  sat_counter #(.W(CNT_W)) u_dwell (
    .clk  (clk),
    .rst  (rst),
    .load (state_d != state_q),
    .inc  (1'b1),
    .q    (dwell_q)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= SYNC;
    else     state_q <= state_d;
  end

  // next state, violation code and phase completion
  always_comb begin
    state_d = state_q;
    viol    = FC_NONE;
    done    = 1'b0;
    if (state_q == FAULT) begin
      if (clr_fault) state_d = SYNC;
    end else if (conflict) begin
      viol = FC_CONFLICT;
    end else if (bad) begin
      viol = FC_ENCODING;
    end else begin
      unique case (state_q)
        SYNC: begin
          if (ns_l == L_STOP && ew_l == L_STOP)
            state_d = ALL_RED;
        end
        ALL_RED: begin
          if (ns_l == L_GO || ew_l == L_GO) begin
            if (dwell_q < CNT_W'(MIN_ALLRED))
              viol = FC_NO_CLEAR;
            else if (ns_l == L_GO)
              state_d = NS_GO;
            else
              state_d = EW_GO;
          end
        end
        NS_GO, EW_GO: begin
          if (own_l == L_GO) begin
            if (dwell_q == CNT_W'(MAX_GREEN))
              viol = FC_LONG;
          end else if (oth_l == L_GO) begin
            viol = FC_NO_CLEAR;
          end else if (dwell_q < CNT_W'(MIN_GREEN)) begin
            viol = FC_SHORT;
          end else begin
            done    = 1'b1;
            state_d = ALL_RED;
          end
        end
        default: ;
      endcase
    end
    if (viol != FC_NONE) state_d = FAULT;
  end

  // next values of the registered outputs
  always_comb begin
    fault_d = fault_q;
    code_d  = code_q;
    done_d  = 1'b0;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    if (state_q == FAULT && clr_fault) begin
      fault_d = 1'b0;
      code_d  = FC_NONE;
    end else if (viol != FC_NONE) begin
      fault_d = 1'b1;
      code_d  = viol;
    end
    if (done) begin
      done_d = 1'b1;
      dir_d  = (state_q == EW_GO);
      if (state_q == EW_GO) cnt_d = cnt_q + 1'b1;
    end
  end

  // output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_q <= 1'b0;
      code_q  <= FC_NONE;
      done_q  <= 1'b0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      fault_q <= fault_d;
      code_q  <= code_d;
      done_q  <= done_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fault       = fault_q;
  assign fault_code  = code_q;
  assign phase_done  = done_q;
  assign phase_dir   = dir_q;
  assign dwell       = dwell_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench for traffic_light_monitor.
// Lamp patterns are scored against a phase-level reference model.
module tb_traffic_light_monitor;

  localparam int MIN_GREEN  = 4;
  localparam int MAX_GREEN  = 32;
  localparam int MIN_ALLRED = 1;
  localparam int CNT_W      = 16;
  localparam int SAT        = 65535;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic NS_green = 1'b0, NS_red = 1'b0;
  logic EW_green = 1'b0, EW_red = 1'b0;
  logic clr_fault = 1'b0;
  logic fault, phase_done, phase_dir;
  logic [2:0] fault_code;
  logic [CNT_W-1:0] dwell, cycle_count;

  traffic_light_monitor #(
    .MIN_GREEN (MIN_GREEN),
    .MAX_GREEN (MAX_GREEN),
    .MIN_ALLRED(MIN_ALLRED),
    .CNT_W     (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .NS_green   (NS_green),
    .NS_red     (NS_red),
    .EW_green   (EW_green),
    .EW_red     (EW_red),
    .clr_fault  (clr_fault),
    .fault      (fault),
    .fault_code (fault_code),
    .phase_done (phase_done),
    .phase_dir  (phase_dir),
    .dwell      (dwell),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int f;
    int c;
    int d;
    int dir;
    int dw;
    int cc;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;

  // reference model: synced flag, which direction owns green
  // (-1 = none), latched fault, and length of the current run
  int m_synced, m_green, m_faulted, m_code;
  int m_run, m_cnt, m_done, m_dir;

  function automatic void chk(string n, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               n, act, exp, $time);
    end
  endfunction

  task automatic model_reset();
    m_synced = 0; m_green = -1; m_faulted = 0; m_code = 0;
    m_run = 0; m_cnt = 0; m_done = 0; m_dir = 0;
  endtask

  task automatic model_step(bit ng, bit nr, bit eg, bit er,
                            bit c, bit r);
    bit chg, ngo, nst, ego, est, own, oth;
    int v;
    if (r) begin
      model_reset();
      return;
    end
    chg = 0; v = 0; m_done = 0;
    ngo = ng && !nr; nst = !ng && nr;
    ego = eg && !er; est = !eg && er;
    if (m_faulted != 0) begin
      if (c) begin
        m_faulted = 0; m_code = 0;
        m_synced = 0; m_green = -1; chg = 1;
      end
    end else begin
      if (ng && eg) v = 1;
      else if (!(ngo || nst) || !(ego || est)) v = 2;
      else if (m_synced == 0) begin
        if (nst && est) begin m_synced = 1; chg = 1; end
      end else if (m_green < 0) begin
        if (ngo || ego) begin
          if (m_run < MIN_ALLRED) v = 3;
          else begin m_green = ngo ? 0 : 1; chg = 1; end
        end
      end else begin
        own = (m_green == 0) ? ngo : ego;
        oth = (m_green == 0) ? ego : ngo;
        if (own) begin
          if (m_run == MAX_GREEN) v = 5;
        end else if (oth) v = 3;
        else if (m_run < MIN_GREEN) v = 4;
        else begin
          m_done = 1; m_dir = m_green;
          if (m_green == 1) m_cnt = (m_cnt + 1) % (SAT + 1);
          m_green = -1; chg = 1;
        end
      end
      if (v != 0) begin m_faulted = 1; m_code = v; chg = 1; end
    end
    m_run = chg ? 1 : ((m_run < SAT) ? m_run + 1 : SAT);
  endtask

  task automatic drive(bit ng, bit nr, bit eg, bit er,
                       bit c = 0, bit r = 0);
    exp_t e;
    @(negedge clk);
    rst = r;
    NS_green = ng; NS_red = nr;
    EW_green = eg; EW_red = er;
    clr_fault = c;
    model_step(ng, nr, eg, er, c, r);
    e.f = m_faulted; e.c = m_code; e.d = m_done;
    e.dir = m_dir; e.dw = m_run; e.cc = m_cnt;
    sb.push_back(e);
  endtask

  task automatic red(int n);
    repeat (n) drive(0, 1, 0, 1);
  endtask

  task automatic green(int d, int n);
    repeat (n) begin
      if (d == 0) drive(1, 0, 0, 1);
      else        drive(0, 1, 1, 0);
    end
  endtask

  task automatic clr();
    drive(0, 1, 0, 1, 1);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_fault"}, int'(fault), 0);
    chk({tag, "_code"},  int'(fault_code), 0);
    chk({tag, "_done"},  int'(phase_done), 0);
    chk({tag, "_dir"},   int'(phase_dir), 0);
    chk({tag, "_dwell"}, int'(dwell), 0);
    chk({tag, "_cnt"},   int'(cycle_count), 0);
  endtask

  // monitor: one expected record per sampled edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("fault", int'(fault), e.f);
        chk("fault_code", int'(fault_code), e.c);
        chk("phase_done", int'(phase_done), e.d);
        if (e.d != 0) chk("phase_dir", int'(phase_dir), e.dir);
        chk("dwell", int'(dwell), e.dw);
        chk("cycle_count", int'(cycle_count), e.cc);
      end
    end
  end

  initial begin
    bit [4:0] g;
    int k;
    model_reset();
    #1;
    chk_zero("por");
    drive(0, 1, 0, 1, 0, 1);
    drive(0, 1, 0, 1, 0, 1);

    // normal NS then EW phase
    red(2); green(0, 6); red(2); green(1, 6); red(2);
    // short green
    green(0, 3); red(1); clr();
    // long green
    red(2); green(0, 40); clr();
    // direct hand-over
    red(2); green(0, 5); drive(0, 1, 1, 0); clr();
    // conflict beats encoding, then resume
    red(2); drive(1, 1, 1, 0); clr();
    red(2); green(0, 5); red(2); green(1, 5); red(1);
    // reach cycle_count = 3, reset mid EW phase
    green(1, 5); red(1);
    green(1, 3);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk_zero("arst");
    model_reset();
    drive(0, 1, 1, 0, 0, 1);
    green(1, 3); red(1); green(0, 5); red(1);

    // randomized traffic with occasional glitches
    repeat (400) begin
      k = $urandom_range(0, 19);
      if (m_faulted != 0 && $urandom_range(0, 2) == 0) clr();
      else if (k == 0) begin
        g = 5'($urandom);
        drive(g[0], g[1], g[2], g[3], g[4]);
      end else if (k == 1) clr();
      else begin
        red($urandom_range(0, 3));
        green($urandom_range(0, 1), $urandom_range(2, 36));
      end
    end
    red(2);

    k = 0;
    while (sb.size() > 0 && k < 10) begin
      @(posedge clk);
      k++;
    end
    #2;
    chk("drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
